// File: rtl/ring_tx_serializer.sv
// Token-ring transmit serializer: builds ACK/NACK/TOKEN/FORWARD/NEW packets and shifts them
// out LSB first with start/stop framing. Define RING_TX_PARITY_EN to add the even-parity bit.
module ring_tx_serializer #(
    parameter int         PKT_W        = 16,
    parameter int         CLKS_PER_BIT = 4,
    parameter logic [3:0] OUR_ADDRESS  = 4'b0001
) (
    input  logic             Clk_R,
    input  logic             Rst_n,
    input  logic             tx_start,
    input  logic [2:0]       tx_data_select,
    input  logic [PKT_W-1:0] fwd_packet,
    input  logic [PKT_W-1:0] node_packet,
    output logic             tx_ready,
    output logic             tx_busy,
    output logic             tx_serial,
    output logic             tx_err,
    output logic [2:0]       tx_state_dbg
);
    localparam int MAX_CNT = (CLKS_PER_BIT > PKT_W) ? CLKS_PER_BIT : PKT_W;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(PKT_W - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd4
`ifdef RING_TX_PARITY_EN
        , S_PARITY = 3'd3
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [CNT_W-1:0] bit_q, bit_d;
    logic [PKT_W-1:0] shift_q, shift_d;
    logic             serial_q, serial_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;
`ifdef RING_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic [PKT_W-1:0] built_pkt;
    logic             sel_legal;
    logic             baud_end;

    always_comb begin
        built_pkt = '0;
        sel_legal = 1'b1;
        case (tx_data_select)
            3'd0: begin built_pkt[2:0] = 3'b000; built_pkt[6:3] = OUR_ADDRESS; end
            3'd1: begin built_pkt[2:0] = 3'b011; built_pkt[6:3] = OUR_ADDRESS; end
            3'd2: built_pkt = fwd_packet;
            3'd3: built_pkt[2:0] = 3'b111;
            3'd4: built_pkt = node_packet;
            default: sel_legal = 1'b0;
        endcase
    end

    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        serial_d = serial_q;
        ready_d  = ready_q;
        err_d    = 1'b0;
`ifdef RING_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (tx_start && sel_legal) begin
                    state_d  = S_START;
                    shift_d  = built_pkt;
`ifdef RING_TX_PARITY_EN
                    parity_d = ^built_pkt;
`endif
                    serial_d = 1'b0;
                    ready_d  = 1'b0;
                    baud_d   = '0;
                    bit_d    = '0;
                end else if (tx_start) begin
                    err_d = 1'b1;
                end
            end
            S_START: begin
                if (baud_end) begin
                    state_d  = S_DATA;
                    baud_d   = '0;
                    serial_d = shift_q[0];
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
`ifdef RING_TX_PARITY_EN
                        state_d  = S_PARITY;
                        serial_d = parity_q;
`else
                        state_d  = S_STOP;
                        serial_d = 1'b1;
`endif
                    end else begin
                        // Next bit comes from position 1 before the shift lands.
                        bit_d    = bit_q + CNT_W'(1);
                        shift_d  = shift_q >> 1;
                        serial_d = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
`ifdef RING_TX_PARITY_EN
            S_PARITY: begin
                if (baud_end) begin
                    state_d  = S_STOP;
                    baud_d   = '0;
                    serial_d = 1'b1;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (baud_end) begin
                    state_d = S_IDLE;
                    baud_d  = '0;
                    ready_d = 1'b1;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: begin
                state_d  = S_IDLE;
                serial_d = 1'b1;
                ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clk_R or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            serial_q <= 1'b1;
            ready_q  <= 1'b1;
            err_q    <= 1'b0;
`ifdef RING_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
`ifdef RING_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx_serial    = serial_q;
    assign tx_ready     = ready_q;
    assign tx_busy      = ~ready_q;
    assign tx_err       = err_q;
    assign tx_state_dbg = state_q;
endmodule
